// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter that shares one downstream request/response channel among N users.
// At most one transaction is outstanding. An optional WAIT timeout returns an error response.
module bus_arbiter_rr #(
  parameter int N         = 2,
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               req_valid,
  input  logic [N-1:0][WIDTH-1:0]    req_data,
  output logic [N-1:0]               req_ready,
  output logic [N-1:0]               rsp_valid,
  output logic [OUT_WIDTH-1:0]       rsp_data,
  output logic                       rsp_err,
  input  logic [N-1:0]               rsp_ready,
  output logic                       dn_valid,
  output logic [WIDTH-1:0]           dn_data,
  input  logic                       dn_ready,
  input  logic                       up_valid,
  input  logic [OUT_WIDTH-1:0]       up_data,
  output logic                       up_ready,
  output logic [$clog2(N)-1:0]       grant,
  output logic                       busy
);
  localparam int GW = $clog2(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] LAST_INIT = GW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [WIDTH-1:0]      payload_q, payload_d;
  logic [OUT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic                  expire;
  int                    cand;

  // Scan from the farthest offset down to 1 so the nearest requester after last_grant wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(last_grant_q) + off) % N;
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  assign expire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    payload_d    = payload_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    rsp_valid    = '0;
    dn_valid     = 1'b0;
    up_ready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // req_ready is combinational, so it must be masked while reset is held.
        if (pick_found && !reset) begin
          req_ready[pick_idx] = 1'b1;
          grant_d             = pick_idx;
          last_grant_d        = pick_idx;
          payload_d           = req_data[pick_idx];
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dn_valid = 1'b1;
        if (dn_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        up_ready = 1'b1;
        if (up_valid) begin
          rsp_data_d = up_data;
          rsp_err_d  = 1'b0;
          state_d    = S_RESPOND;
        end else if (expire) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESPOND: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) state_d = rsp_err_q ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        // A late beat from the timed-out transaction is swallowed here.
        up_ready = 1'b1;
        if (up_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_INIT;
      payload_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      payload_q    <= payload_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dn_data  = payload_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule
